// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the nibble-serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int SLICE_W = 4;

    // Counter width for NIB slices; a single-slice add still needs one bit.
    function automatic int idx_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_add_ctrl_nibble_add_reg.sv
`default_nettype none
// ============================================================================
// Module      : nibble_add_reg
// Description : 4-bit adder slice with registered sum and carry-out.
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_add_reg
    import serial_add_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            {cout, sum} <= {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : WIDTH-bit adder sequenced through one registered nibble slice.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int               NIB      = WIDTH / SLICE_W;
    localparam int               IDX_W    = idx_width(NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    state_t                         r_state;
    logic [IDX_W-1:0]               r_idx;
    logic [IDX_W-1:0]               r_prev_idx;
    logic [NIB-1:0][SLICE_W-1:0]    r_a;
    logic [NIB-1:0][SLICE_W-1:0]    r_b;
    logic                           r_cin;
    logic [NIB-1:0][SLICE_W-1:0]    r_sum;
    logic                           r_cout;
    logic                           r_in_ready;
    logic                           r_out_valid;
    logic                           r_busy;

    logic [SLICE_W-1:0]             w_slice_a;
    logic [SLICE_W-1:0]             w_slice_b;
    logic                           w_slice_cin;
    logic [SLICE_W-1:0]             w_slice_sum;
    logic                           w_slice_cout;

    // The slice only sees operands while issuing; otherwise it adds zeros.
    always_comb begin
        w_slice_a   = '0;
        w_slice_b   = '0;
        w_slice_cin = 1'b0;
        if (r_state == RUN) begin
            w_slice_a   = r_a[r_idx];
            w_slice_b   = r_b[r_idx];
            w_slice_cin = (r_idx == '0) ? r_cin : w_slice_cout;
        end
    end

    nibble_add_reg u_slice (
        .clk  (clk),
        .rst  (rst),
        .a    (w_slice_a),
        .b    (w_slice_b),
        .cin  (w_slice_cin),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // r_prev_idx trails r_idx by one edge: it names the nibble whose slice
    // result is visible now, which is the one to write back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_prev_idx  <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_cin       <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_cin      <= in_cin;
                        r_idx      <= '0;
                        r_state    <= RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                RUN: begin
                    r_prev_idx <= r_idx;
                    if (r_idx != '0) begin
                        r_sum[r_prev_idx] <= w_slice_sum;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= DRAIN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DRAIN: begin
                    r_sum[r_prev_idx] <= w_slice_sum;
                    r_cout            <= w_slice_cout;
                    r_out_valid       <= 1'b1;
                    r_state           <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;

endmodule
`default_nettype wire
